// File: rtl/anemo_nmea_sequencer_pkg.sv
// Shared types, ASCII constants and helpers for the anemometer NMEA sequencer.
// Build option: NMEA_CHECKSUM_EN appends '*', H1, H0 to every sentence.
package nmea_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DATA,
        CONVERT,
        SEND,
        DONE
    } state_t;

    localparam logic [7:0] ASC_DOLLAR = 8'h24;
    localparam logic [7:0] ASC_COMMA  = 8'h2C;
    localparam logic [7:0] ASC_STAR   = 8'h2A;
    localparam logic [7:0] ASC_N      = 8'h4E;
    localparam logic [7:0] ASC_A      = 8'h41;
    localparam logic [7:0] ASC_V      = 8'h56;
    localparam logic [7:0] ASC_M      = 8'h4D;
    localparam logic [7:0] ASC_W      = 8'h57;
    localparam logic [7:0] ASC_ZERO   = 8'h30;
    localparam logic [7:0] ASC_CR     = 8'h0D;
    localparam logic [7:0] ASC_LF     = 8'h0A;

    // Byte position of the status letter; the checksum covers bytes 1..this one.
    localparam int STATUS_IDX = 13;

`ifdef NMEA_CHECKSUM_EN
    localparam int SENTENCE_LEN = 19;
`else
    localparam int SENTENCE_LEN = 16;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/anemo_nmea_sequencer_if.sv
// Byte stream towards the NMEA UART transmitter (valid/ready handshake).
interface anemo_nmea_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/anemo_nmea_sequencer_bin8_to_bcd3.sv
// Sequential double-dabble: 8-bit binary to three BCD digits in 8 iterations.
// done pulses for one cycle; bcd holds the result until the next start.
module bin8_to_bcd3 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);
    logic [19:0] shift;
    logic [3:0]  iter;

    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int d = 0; d < 3; d++) begin
            if (t[8 + 4*d +: 4] >= 4'd5)
                t[8 + 4*d +: 4] = t[8 + 4*d +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // Load on start, then one add-3/shift iteration per clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift <= '0;
            iter  <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                shift <= {12'd0, bin};
                iter  <= 4'd8;
            end else if (iter != 4'd0) begin
                shift <= dabble_step(shift);
                iter  <= iter - 4'd1;
                if (iter == 4'd1)
                    done <= 1'b1;
            end
        end
    end

    assign bcd = shift[19:8];

endmodule

// File: rtl/anemo_nmea_sequencer.sv
// Periodic anemometer launch, timed wait for data, BCD conversion and
// MWV sentence streaming to the NMEA UART.
// Build option: NMEA_CHECKSUM_EN adds the '*HH' checksum field.
module anemo_nmea_sequencer
    import nmea_seq_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
    parameter logic [15:0] TALKER_ID      = "II"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       anemo_start,
    input  logic [7:0] anemo_data,
    input  logic       anemo_valid,
    anemo_nmea_sequencer_if.master tx,
    output logic       busy,
    output logic [7:0] timeout_cnt,
    output logic [7:0] overrun_cnt
);
    state_t      state, state_next;
    logic [31:0] period_cnt;
    logic [31:0] wait_cnt;
    logic        tick, valid_prev, valid_edge, wait_expired;
    logic        status_ok;
    logic        conv_start, conv_done;
    logic [7:0]  conv_bin;
    logic [11:0] bcd;
    logic [4:0]  byte_idx;
    logic        xfer, last_byte;
    logic [7:0]  byte_sel;
`ifdef NMEA_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign tick         = enable && (period_cnt == PERIOD_CYCLES - 1);
    assign valid_edge   = anemo_valid && !valid_prev;
    assign wait_expired = (wait_cnt == TIMEOUT_CYCLES - 1);
    assign xfer         = tx.tx_valid && tx.tx_ready;
    assign last_byte    = (byte_idx == 5'(SENTENCE_LEN - 1));

    assign anemo_start  = (state == START);
    assign busy         = (state != IDLE);
    assign tx.tx_valid  = (state == SEND);
    assign tx.tx_data   = (state == SEND) ? byte_sel : 8'h00;

    // Launch timer, parked at zero while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            period_cnt <= '0;
        else if (!enable || tick)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + 32'd1;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state and converter launch; a fresh valid edge beats the timeout
    always_comb begin
        state_next = state;
        conv_start = 1'b0;
        conv_bin   = 8'd0;
        case (state)
            IDLE:      if (tick) state_next = START;
            START:     state_next = WAIT_DATA;
            WAIT_DATA: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (valid_edge) begin
                    state_next = CONVERT;
                    conv_start = 1'b1;
                    conv_bin   = anemo_data;
                end else if (wait_expired) begin
                    state_next = CONVERT;
                    conv_start = 1'b1;
                end
            end
            CONVERT:   if (conv_done) state_next = SEND;
            SEND:      if (xfer && last_byte) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Edge history, wait timer, reading status and event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_prev  <= 1'b0;
            wait_cnt    <= '0;
            status_ok   <= 1'b0;
            timeout_cnt <= '0;
            overrun_cnt <= '0;
        end else begin
            valid_prev <= anemo_valid;
            if (state == START)
                wait_cnt <= '0;
            else if (state == WAIT_DATA)
                wait_cnt <= wait_cnt + 32'd1;
            if (state == WAIT_DATA && enable) begin
                if (valid_edge) begin
                    status_ok <= 1'b1;
                end else if (wait_expired) begin
                    status_ok   <= 1'b0;
                    timeout_cnt <= sat_inc(timeout_cnt);
                end
            end
            if (tick && state != IDLE)
                overrun_cnt <= sat_inc(overrun_cnt);
        end
    end

    // Sentence position and running checksum, advanced on each accepted byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx <= '0;
`ifdef NMEA_CHECKSUM_EN
            checksum <= '0;
`endif
        end else if (state == CONVERT) begin
            byte_idx <= '0;
`ifdef NMEA_CHECKSUM_EN
            checksum <= '0;
`endif
        end else if (xfer) begin
            byte_idx <= byte_idx + 5'd1;
`ifdef NMEA_CHECKSUM_EN
            if (byte_idx != 5'd0 && byte_idx <= 5'(STATUS_IDX))
                checksum <= checksum ^ byte_sel;
`endif
        end
    end

    // Byte selected for the current sentence position
    always_comb begin
        byte_sel = 8'h00;
        case (byte_idx)
            5'd0:    byte_sel = ASC_DOLLAR;
            5'd1:    byte_sel = TALKER_ID[15:8];
            5'd2:    byte_sel = TALKER_ID[7:0];
            5'd3:    byte_sel = ASC_M;
            5'd4:    byte_sel = ASC_W;
            5'd5:    byte_sel = ASC_V;
            5'd6:    byte_sel = ASC_COMMA;
            5'd7:    byte_sel = ASC_ZERO + {4'h0, bcd[11:8]};
            5'd8:    byte_sel = ASC_ZERO + {4'h0, bcd[7:4]};
            5'd9:    byte_sel = ASC_ZERO + {4'h0, bcd[3:0]};
            5'd10:   byte_sel = ASC_COMMA;
            5'd11:   byte_sel = ASC_N;
            5'd12:   byte_sel = ASC_COMMA;
            5'd13:   byte_sel = status_ok ? ASC_A : ASC_V;
`ifdef NMEA_CHECKSUM_EN
            5'd14:   byte_sel = ASC_STAR;
            5'd15:   byte_sel = hex_ascii(checksum[7:4]);
            5'd16:   byte_sel = hex_ascii(checksum[3:0]);
            5'd17:   byte_sel = ASC_CR;
            5'd18:   byte_sel = ASC_LF;
`else
            5'd14:   byte_sel = ASC_CR;
            5'd15:   byte_sel = ASC_LF;
`endif
            default: byte_sel = 8'h00;
        endcase
    end

    bin8_to_bcd3 u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (conv_bin),
        .done  (conv_done),
        .bcd   (bcd)
    );

endmodule
